// File: rtl/freq_lock_monitor.sv
// Turns per-window frequency-meter counts into lock / stall / error status in the ref_clk domain.
// Optional min/max tracking while locked is built only when FREQ_LOCK_MONITOR_MINMAX_EN is defined.
module freq_lock_monitor #(
  parameter int CNT_W            = 28,
  parameter int EXPECTED_CYCLES  = 156250000,
  parameter int TOLERANCE_CYCLES = 1000,
  parameter int LOCK_COUNT       = 4,
  parameter int UNLOCK_COUNT     = 2,
  parameter int TIMEOUT_CYCLES   = 400000000
) (
  input  logic             ref_clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] meas_cycles,
  input  logic             meas_valid,
  input  logic             clr_sticky,
  output logic [CNT_W-1:0] last_cycles,
  output logic             status_strobe,
  output logic             in_range,
  output logic             too_fast,
  output logic             too_slow,
  output logic             locked,
  output logic             lock_lost,
  output logic             lock_lost_sticky,
  output logic             stalled,
  output logic [CNT_W-1:0] min_cycles,
  output logic [CNT_W-1:0] max_cycles
);

  // Bounds are clamped to the representable count range, so they need one extra bit.
  localparam longint EXP_L   = longint'(EXPECTED_CYCLES);
  localparam longint TOL_L   = longint'(TOLERANCE_CYCLES);
  localparam longint CNT_MAX = (longint'(1) << CNT_W) - 1;
  localparam longint LO_L    = (EXP_L > TOL_L) ? (EXP_L - TOL_L) : longint'(0);
  localparam longint HI_L    = ((EXP_L + TOL_L) > CNT_MAX) ? CNT_MAX : (EXP_L + TOL_L);
  localparam logic [CNT_W:0] LO = (CNT_W+1)'(LO_L);
  localparam logic [CNT_W:0] HI = (CNT_W+1)'(HI_L);

  localparam int RUN_W  = $clog2(LOCK_COUNT + 1);
  localparam int MISS_W = $clog2(UNLOCK_COUNT + 1);
  localparam int WD_W   = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [RUN_W-1:0]  RUN_LAST  = RUN_W'(LOCK_COUNT - 1);
  localparam logic [RUN_W-1:0]  RUN_FULL  = RUN_W'(LOCK_COUNT);
  localparam logic [MISS_W-1:0] MISS_LAST = MISS_W'(UNLOCK_COUNT - 1);
  localparam logic [WD_W-1:0]   WD_LAST   = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [WD_W-1:0]   WD_FULL   = WD_W'(TIMEOUT_CYCLES);

  typedef enum logic [0:0] {ACQUIRE, LOCKED} state_t;

  state_t             state;
  logic [RUN_W-1:0]   run_cnt;
  logic [MISS_W-1:0]  miss_cnt;
  logic [WD_W-1:0]    wd_cnt;

  logic [CNT_W:0] meas_ext;
  logic           slow_now, fast_now, in_now;
  logic           lock_hit, miss_hit, stall_hit, lost_evt;

  assign meas_ext  = {1'b0, meas_cycles};
  assign slow_now  = (meas_ext < LO);
  assign fast_now  = (meas_ext > HI);
  assign in_now    = !slow_now && !fast_now;

  // A stall only fires on a cycle with no valid, so a coincident valid always wins.
  assign lock_hit  = meas_valid && (state == ACQUIRE) && in_now && (run_cnt == RUN_LAST);
  assign miss_hit  = meas_valid && (state == LOCKED) && !in_now && (miss_cnt == MISS_LAST);
  assign stall_hit = !meas_valid && (wd_cnt == WD_LAST);
  assign lost_evt  = miss_hit || (stall_hit && (state == LOCKED));

  assign locked = (state == LOCKED);

  always_ff @(posedge ref_clk or posedge rst) begin
    if (rst) begin
      state            <= ACQUIRE;
      run_cnt          <= '0;
      miss_cnt         <= '0;
      wd_cnt           <= '0;
      last_cycles      <= '0;
      status_strobe    <= 1'b0;
      in_range         <= 1'b0;
      too_fast         <= 1'b0;
      too_slow         <= 1'b0;
      lock_lost        <= 1'b0;
      lock_lost_sticky <= 1'b0;
      stalled          <= 1'b0;
    end else begin
      status_strobe <= meas_valid;
      lock_lost     <= lost_evt;

      if (lost_evt)
        lock_lost_sticky <= 1'b1;
      else if (clr_sticky)
        lock_lost_sticky <= 1'b0;

      if (meas_valid) begin
        last_cycles <= meas_cycles;
        in_range    <= in_now;
        too_fast    <= fast_now;
        too_slow    <= slow_now;
        wd_cnt      <= '0;
        stalled     <= 1'b0;
        case (state)
          ACQUIRE: begin
            if (lock_hit) begin
              state    <= LOCKED;
              run_cnt  <= RUN_FULL;
              miss_cnt <= '0;
            end else if (in_now) begin
              run_cnt  <= run_cnt + 1'b1;
            end else begin
              run_cnt  <= '0;
            end
          end
          LOCKED: begin
            if (miss_hit) begin
              state    <= ACQUIRE;
              run_cnt  <= '0;
              miss_cnt <= '0;
            end else if (!in_now) begin
              miss_cnt <= miss_cnt + 1'b1;
            end else begin
              miss_cnt <= '0;
            end
          end
          default: state <= ACQUIRE;
        endcase
      end else begin
        if (wd_cnt != WD_FULL)
          wd_cnt <= wd_cnt + 1'b1;
        if (stall_hit) begin
          stalled  <= 1'b1;
          state    <= ACQUIRE;
          run_cnt  <= '0;
          miss_cnt <= '0;
        end
      end
    end
  end

`ifdef FREQ_LOCK_MONITOR_MINMAX_EN
  logic [CNT_W-1:0] min_r, max_r;

  // Reload on lock entry, then widen with every measurement accepted while locked.
  always_ff @(posedge ref_clk or posedge rst) begin
    if (rst) begin
      min_r <= '0;
      max_r <= '0;
    end else if (lock_hit) begin
      min_r <= meas_cycles;
      max_r <= meas_cycles;
    end else if (meas_valid && (state == LOCKED)) begin
      if (meas_cycles < min_r) min_r <= meas_cycles;
      if (meas_cycles > max_r) max_r <= meas_cycles;
    end
  end

  assign min_cycles = min_r;
  assign max_cycles = max_r;
`else
  assign min_cycles = '0;
  assign max_cycles = '0;
`endif

endmodule

// File: doc/freq_lock_monitor.md
# freq_lock_monitor

Consumes the per-window cycle count produced by the frequency meter and turns it into clock-health status for the `ref_clk` domain. It tracks each measurement against an expected-count window and qualifies lock with hysteresis, so brief glitches do not toggle lock. It also flags a stalled meter and latches a sticky lock-loss error for software or the system controller.

## Interface
- `CNT_W`, 28: width of the incoming count; matches the meter output width.
- `EXPECTED_CYCLES`, 156250000: nominal count per measurement window.
- `TOLERANCE_CYCLES`, 1000: allowed ± deviation; the bounds are inclusive.
- `LOCK_COUNT`, 4: consecutive in-range measurements needed to declare lock; must be ≥1.
- `UNLOCK_COUNT`, 2: consecutive out-of-range measurements needed to drop lock; must be ≥1.
- `TIMEOUT_CYCLES`, 400000000: `ref_clk` cycles allowed with no `meas_valid` before stall; must be ≥2.

Ports:
- `ref_clk` in 1: the block's single clock.
- `rst` in 1: reset, asynchronous and active-high.
- `meas_cycles` in CNT_W: measured test-clock count; sampled only when `meas_valid` is high.
- `meas_valid` in 1: single-cycle strobe, one per measurement window.
- `clr_sticky` in 1: clears `lock_lost_sticky`.
- `last_cycles` out CNT_W: last accepted measurement.
- `status_strobe` out 1: pulses one cycle when the status outputs update.
- `in_range`, `too_fast`, `too_slow` out 1 each: classification of the last measurement; exactly one is high after the first measurement.
- `locked` out 1: lock qualified.
- `lock_lost` out 1: one-cycle pulse on the LOCKED→ACQUIRE transition.
- `lock_lost_sticky` out 1: latched lock-loss or stall error.
- `stalled` out 1: watchdog expired.
- `min_cycles`, `max_cycles` out CNT_W: extremes since lock was last achieved (see Configuration).

## Operation
- Bounds are constants computed in CNT_W+1 bits.
  - `LO = max(EXPECTED_CYCLES − TOLERANCE_CYCLES, 0)`.
  - `HI = min(EXPECTED_CYCLES + TOLERANCE_CYCLES, 2^CNT_W − 1)`.
- Classification of an accepted `meas_cycles`:
  - `too_slow` if the count is < LO.
  - `too_fast` if the count is > HI.
  - `in_range` otherwise.
- The FSM has two states, ACQUIRE (reset state) and LOCKED.
  - **ACQUIRE:** an in-range measurement increments the run counter, which saturates at LOCK_COUNT. An out-of-range measurement clears it. When the run counter reaches LOCK_COUNT, go to LOCKED, clear the miss counter, and load min/max with the current count.
  - **LOCKED:** an out-of-range measurement increments the miss counter. An in-range measurement clears it. When the miss counter reaches UNLOCK_COUNT:
    - go to ACQUIRE and clear the run counter;
    - pulse `lock_lost`;
    - set `lock_lost_sticky`.
- The watchdog counter clears on every `meas_valid` and otherwise increments, saturating.
  - When it reaches TIMEOUT_CYCLES, `stalled` is set and the FSM is forced to ACQUIRE with both counters cleared.
  - If the FSM was in LOCKED, `lock_lost` pulses and `lock_lost_sticky` sets.
  - `stalled` clears on the next `meas_valid`.
- Sticky clear: `clr_sticky` clears `lock_lost_sticky`. If a set event occurs in the same cycle, the set wins.

## Timing
- All registers reset to 0, and the FSM resets to ACQUIRE. Every output is 0 during and after reset until the first event.
- Reset asserted mid-lock drops `locked` immediately (asynchronously), with no `lock_lost` pulse.
- Latency for a `meas_valid` at cycle N: the following all update at N+1.
  - `last_cycles` and the classification flags;
  - `status_strobe`;
  - FSM state, `locked`, and `lock_lost`;
  - min/max.
- `meas_valid` may arrive every cycle; each assertion is processed independently with no loss.
- Watchdog: with no `meas_valid` since cycle N, `stalled` rises at cycle N+TIMEOUT_CYCLES+1.
- If `meas_valid` coincides with the watchdog reaching terminal count, the valid wins: no stall is raised and the measurement is processed normally.
- A measurement that arrives while `stalled` is high is classified and counted normally, and `stalled` falls at N+1.

## Configuration
- Macro: `FREQ_LOCK_MONITOR_MINMAX_EN`.
- **Defined:**
  - While LOCKED, `min_cycles` and `max_cycles` track the extremes of every accepted measurement.
  - They are reloaded on entry to LOCKED.
  - They hold their values in ACQUIRE.
- **Undefined:** the ports remain, but are tied to 0 and no tracking registers are built.

## Test plan
Parameters for all scenarios: EXPECTED=1000, TOL=10, LOCK=4, UNLOCK=2, TIMEOUT=100.

- **Bounds:** send counts 989, 990, 1010, 1011 → classifications are too_slow, in_range, in_range, too_fast, each with a `status_strobe` at N+1.
- **Acquire:** send four 1000s → `locked` rises one cycle after the 4th valid. Send 1000, 1000, 1200, then four 1000s → `locked` rises only after the last 4.
- **Hysteresis:** while locked, send 1200, 1000, 1200 → stays locked. Then send 1200, 1200 → `lock_lost` pulses once, `locked`=0, `lock_lost_sticky`=1.
- **Stall:** while locked, send no valids for 100 cycles → `stalled`=1, `locked`=0, `lock_lost` pulses. Then send one valid of 1000 → `stalled`=0 at N+1, run counter=1.
- **Sticky/reset:** assert `clr_sticky` in the same cycle as an unlock event → sticky stays 1. Assert `clr_sticky` alone → sticky=0. Assert `rst` while locked → all outputs are 0 immediately.
- **MINMAX_EN:** lock on 1000, then send 995 and 1008 → `min_cycles`=995, `max_cycles`=1008. With the macro undefined → both are 0.
